cache_miss_refill: RTL

- Miss handler for the 4-way set-associative data cache. It is the consumer of the pseudo-LRU replacement block: it takes the victim way that block reports and evicts that way.
- A dirty victim line is first copied into a local line buffer and written back as a burst. The missing line is then fetched as a read burst and written into the data RAM.
- Last step: it writes the new tag and drives the one-hot access/update pair back to the replacement block, so the refilled way becomes most-recently-used.

---
 rtl/cache_miss_refill.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cache_miss_refill.sv
// Miss handler for the 4-way set-associative data cache. It evicts the victim
// way chosen by the replacement block. A dirty victim line is read into a
// local buffer and written back as a burst. The missing line is then fetched
// and written into the data RAM. Last, the tag is written and the refilled way
// is reported back to the replacement block as most-recently-used.
module cache_miss_refill #(
    parameter int ASSOC_NUM  = 4,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32,
    parameter int INDEX_W    = 7,
    parameter int DATA_W     = 32,
    localparam int WAY_W     = $clog2(ASSOC_NUM),
    localparam int WORD_W    = $clog2(LINE_WORDS),
    localparam int OFFSET_W  = $clog2(LINE_WORDS * DATA_W / 8),
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic [WAY_W-1:0]     victim_way,
    input  logic                 victim_dirty,
    input  logic [TAG_W-1:0]     victim_tag,
    output logic                 vic_rd_en,
    output logic [WORD_W-1:0]    vic_rd_word,
    input  logic [DATA_W-1:0]    vic_rd_data,
    output logic                 wb_req_valid,
    input  logic                 wb_req_ready,
    output logic [ADDR_W-1:0]    wb_addr,
    output logic                 wb_data_valid,
    input  logic                 wb_data_ready,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_data_last,
    output logic                 rd_req_valid,
    input  logic                 rd_req_ready,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_data_valid,
    input  logic [DATA_W-1:0]    rd_data,
    input  logic                 rd_data_last,
    output logic                 refill_we,
    output logic [WAY_W-1:0]     refill_way,
    output logic [WORD_W-1:0]    refill_word,
    output logic [DATA_W-1:0]    refill_data,
    output logic                 tag_we,
    output logic [WAY_W-1:0]     tag_way,
    output logic [INDEX_W-1:0]   tag_index,
    output logic [TAG_W-1:0]     tag_wdata,
    output logic                 lru_update,
    output logic [ASSOC_NUM-1:0] lru_access,
    output logic                 done,
    output logic                 burst_err
);

    localparam int CNT_W = WORD_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, WB_READ, WB_REQ, WB_DATA, RD_REQ, RD_DATA, COMMIT
    } state_e;

    state_e             state_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   vtag_q;
    logic [INDEX_W-1:0] index_q;
    logic [WAY_W-1:0]   way_q;
    // One counter serves the victim read (0..LINE_WORDS), the writeback
    // stream and the refill beats; the extra bit flags overlong refills.
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic [DATA_W-1:0]  buf_q [LINE_WORDS];

    logic               in_range;
    logic [WORD_W-1:0]  cap_idx;
    logic               commit;
    logic               unused_offset;

    assign unused_offset = ^miss_addr[OFFSET_W-1:0];
    assign in_range      = (cnt_q < CNT_FULL);
    assign cap_idx       = WORD_W'(cnt_q - CNT_W'(1));
    assign commit        = (state_q == COMMIT);

    // Control FSM: request latching, burst counting and error tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tag_q   <= '0;
            vtag_q  <= '0;
            index_q <= '0;
            way_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_valid) begin
                        tag_q   <= miss_addr[ADDR_W-1 -: TAG_W];
                        index_q <= miss_addr[OFFSET_W +: INDEX_W];
                        way_q   <= victim_way;
                        vtag_q  <= victim_tag;
                        cnt_q   <= '0;
                        state_q <= victim_dirty ? WB_READ : RD_REQ;
                    end
                end
                WB_READ: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        state_q <= WB_REQ;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WB_REQ: begin
                    if (wb_req_ready) state_q <= WB_DATA;
                end
                WB_DATA: begin
                    if (wb_data_ready) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= RD_REQ;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                RD_REQ: begin
                    if (rd_req_ready) begin
                        cnt_q   <= '0;
                        state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rd_data_valid) begin
                        if (in_range) cnt_q <= cnt_q + CNT_W'(1);
                        else          err_q <= 1'b1;
                        if (rd_data_last) begin
                            if (cnt_q != CNT_LAST) err_q <= 1'b1;
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Victim line buffer: word k-1 arrives while the counter reads k
    always_ff @(posedge clk) begin
        if (state_q == WB_READ && cnt_q != '0) buf_q[cap_idx] <= vic_rd_data;
    end

    // Output decode from the registered state; data fields are zero when idle
    always_comb begin
        miss_ready    = (state_q == IDLE);
        vic_rd_en     = (state_q == WB_READ) && in_range;
        vic_rd_word   = vic_rd_en ? cnt_q[WORD_W-1:0] : '0;
        wb_req_valid  = (state_q == WB_REQ);
        wb_addr       = wb_req_valid ? {vtag_q, index_q, {OFFSET_W{1'b0}}} : '0;
        wb_data_valid = (state_q == WB_DATA);
        wb_data       = wb_data_valid ? buf_q[cnt_q[WORD_W-1:0]] : '0;
        wb_data_last  = wb_data_valid && (cnt_q == CNT_LAST);
        rd_req_valid  = (state_q == RD_REQ);
        rd_addr       = rd_req_valid ? {tag_q, index_q, {OFFSET_W{1'b0}}} : '0;
        refill_we     = (state_q == RD_DATA) && rd_data_valid && in_range;
        refill_way    = refill_we ? way_q : '0;
        refill_word   = refill_we ? cnt_q[WORD_W-1:0] : '0;
        refill_data   = refill_we ? rd_data : '0;
        tag_we        = commit;
        tag_way       = commit ? way_q : '0;
        tag_index     = commit ? index_q : '0;
        tag_wdata     = commit ? tag_q : '0;
        lru_update    = commit;
        lru_access    = commit ? (ASSOC_NUM'(1) << way_q) : '0;
        done          = commit;
        burst_err     = err_q;
    end

endmodule
